// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared PCSrc encodings, vector constants and PC arithmetic
package if_stage_pkg;

    typedef enum logic [2:0] {
        PCSRC_SEQ    = 3'b000,
        PCSRC_BRANCH = 3'b001,
        PCSRC_J      = 3'b010,
        PCSRC_JR     = 3'b011,
        PCSRC_ILLOP  = 3'b100,
        PCSRC_XADR   = 3'b101
    } pc_src_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    // Increment never touches the supervisor bit; the low 31 bits wrap.
    function automatic logic [31:0] pc_inc(input logic [31:0] cur_pc);
        return {cur_pc[31], cur_pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with write enable, flush, stall-proof flush and valid bit
module if_id_reg #(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic              flush,
    input  logic              hard_flush,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] bubble_data,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              loaded,
    output logic              bubbled
);

    // hard_flush beats a stall; a plain flush is ignored while stalled.
    always_comb begin
        bubbled = hard_flush || (write_en && flush);
        loaded  = !hard_flush && write_en && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= RESET_DATA;
            valid <= 1'b0;
        end else if (bubbled) begin
            data  <= bubble_data;
            valid <= 1'b0;
        end else if (loaded) begin
            data  <= load_data;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch: PC register, next-PC mux and IF/ID register
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        if_flush,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic [2:0]  id_pc_src,
    input  logic [31:0] id_rs_data,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] next_pc;
    logic        loaded;
    logic        bubbled;

    assign imem_addr = pc;

    always_comb begin
        pc_plus4    = pc_inc(pc);
        jump_target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};
        // A user-mode jr cannot raise the supervisor bit.
        jr_target   = {if_id_pc_plus4[31] & id_rs_data[31], id_rs_data[30:0]};
        next_pc     = pc_plus4;
        if (ex_branch_taken) begin
            next_pc = ex_branch_target;
        end else if (!pc_write) begin
            next_pc = pc;
        end else begin
            case (pc_src_e'(id_pc_src))
                PCSRC_J:     next_pc = jump_target;
                PCSRC_JR:    next_pc = jr_target;
                PCSRC_ILLOP: next_pc = ILLOP_VEC;
                PCSRC_XADR:  next_pc = XADR_VEC;
                default:     next_pc = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Bubbles keep pc_plus4 so an exception in the bubble slot can return.
    if_id_reg #(
        .DATA_W     (64),
        .RESET_DATA ({NOP_INSTR, 32'h0000_0000})
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .write_en    (if_id_write),
        .flush       (if_flush),
        .hard_flush  (ex_branch_taken && if_flush),
        .load_data   ({imem_rdata, pc_plus4}),
        .bubble_data ({NOP_INSTR, pc_plus4}),
        .data        ({if_id_instr, if_id_pc_plus4}),
        .valid       (if_id_valid),
        .loaded      (loaded),
        .bubbled     (bubbled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (loaded) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (bubbled) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end

endmodule
